// File: rtl/eaglesong_pkg.sv
// Shared definitions for the Eaglesong digest requester: FSM state
// encoding, response error codes and the largest message length the
// digest core accepts.
package eaglesong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_LOW  = 3'd2,
      ST_WAIT_HIGH = 3'd3,
      ST_RESP      = 3'd4
   } state_e;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_BAD_LEN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam int MAX_LEN_BYTES = 32;

   // A length is usable by the core when it is between 1 and MAX_LEN_BYTES.
   function automatic logic len_is_valid(input logic [6:0] len);
      return (len != 7'd0) && (len <= 7'(MAX_LEN_BYTES));
   endfunction

endpackage

// File: rtl/eaglesong_digest_requester.sv
// Eaglesong digest requester: accepts one message at a time, launches the
// external digest core, waits for its done flag to go low and then high
// (the flag left over from the previous job is stale), and returns the
// digest on a valid/ready response channel.
// Optional macro EAGLESONG_TIMEOUT_EN adds an abort counter started at
// launch; after TIMEOUT_CYCLES cycles without a result the job is answered
// with a timeout error and a zero digest.
module eaglesong_digest_requester
   import eaglesong_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [255:0] req_msg,
   input  logic [6:0]   req_len,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [255:0] rsp_digest,
   output logic [1:0]   rsp_err,
   output logic [255:0] core_input_val,
   output logic [6:0]   core_input_length_bytes,
   output logic         core_start_eval,
   input  logic [255:0] core_output_val,
   input  logic         core_eval_output_ready
);

   state_e        state_q, state_d;
   logic [255:0]  msg_q, msg_d;
   logic [6:0]    len_q, len_d;
   logic [255:0]  digest_q, digest_d;
   logic [1:0]    err_q, err_d;

`ifdef EAGLESONG_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Next-state, request capture, response capture and abort logic.
   always_comb begin
      state_d  = state_q;
      msg_d    = msg_q;
      len_d    = len_q;
      digest_d = digest_q;
      err_d    = err_q;
`ifdef EAGLESONG_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               msg_d = req_msg;
               len_d = req_len;
`ifdef EAGLESONG_TIMEOUT_EN
               cnt_d = '0;
`endif
               if (len_is_valid(req_len)) begin
                  state_d = ST_LAUNCH;
               end else begin
                  // Unusable length never reaches the core.
                  state_d  = ST_RESP;
                  err_d    = ERR_BAD_LEN;
                  digest_d = '0;
               end
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            // A high flag here belongs to the previous job.
            if (!core_eval_output_ready) state_d = ST_WAIT_HIGH;
         end
         ST_WAIT_HIGH: begin
            if (core_eval_output_ready) begin
               state_d  = ST_RESP;
               digest_d = core_output_val;
               err_d    = ERR_OK;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef EAGLESONG_TIMEOUT_EN
      // A genuine result arriving on the last cycle still wins over the abort.
      if (state_q == ST_LAUNCH || state_q == ST_WAIT_LOW || state_q == ST_WAIT_HIGH) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && state_d != ST_RESP) begin
            state_d  = ST_RESP;
            err_d    = ERR_TIMEOUT;
            digest_d = '0;
         end
      end
`endif
   end

   // State and datapath registers, cleared immediately by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         msg_q    <= '0;
         len_q    <= '0;
         digest_q <= '0;
         err_q    <= ERR_OK;
`ifdef EAGLESONG_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         msg_q    <= msg_d;
         len_q    <= len_d;
         digest_q <= digest_d;
         err_q    <= err_d;
`ifdef EAGLESONG_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign req_ready               = (state_q == ST_IDLE) && !rst;
   assign core_start_eval         = (state_q == ST_LAUNCH);
   assign rsp_valid               = (state_q == ST_RESP);
   assign rsp_digest              = digest_q;
   assign rsp_err                 = err_q;
   assign core_input_val          = msg_q;
   assign core_input_length_bytes = len_q;

endmodule
